// File: rtl/mono_hit_filter.sv
// Consumer of the mono data-RX FIFO: computes ToT, filters by threshold and matrix bounds,
// and forwards surviving hits on a valid/ready stream with saturating hit/drop counters.
module mono_hit_filter #(
    parameter int unsigned NUM_COLS = 36,
    parameter int unsigned NUM_ROWS = 129,
    parameter logic [15:0] CNT_MAX  = 16'hFFFF
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        CONF_EN,
    input  logic        CONF_RAW,
    input  logic [7:0]  CONF_TOT_MIN,
    input  logic        CNT_CLR,
    input  logic        IN_EMPTY,
    input  logic [31:0] IN_DATA,
    output logic        IN_READ,
    output logic [31:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] HIT_CNT,
    output logic [15:0] DROP_CNT
);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        POP  = 5'b00010,
        CAPT = 5'b00100,
        EVAL = 5'b01000,
        SEND = 5'b10000
    } state_t;

    state_t      state_q, state_d;
    logic        in_read_q, in_read_d;
    logic [31:0] word_q, word_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [7:0]  tot;
    logic        keep;
    logic        hit_inc;
    logic        drop_inc;

    // ToT wraps modulo 256, so a TE that rolled over past LE still yields the short pulse width.
    always_comb begin
        tot  = word_q[21:14] - word_q[29:22];
        keep = CONF_RAW ||
               ((tot >= CONF_TOT_MIN) &&
                (32'(word_q[5:0]) < NUM_COLS) &&
                (32'(word_q[13:6]) < NUM_ROWS));
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        hit_inc     = 1'b0;
        drop_inc    = 1'b0;

        unique case (state_q)
            IDLE: if (CONF_EN && !IN_EMPTY) state_d = POP;
            POP:  state_d = CAPT;
            CAPT: begin
                word_d  = IN_DATA;
                state_d = EVAL;
            end
            EVAL: begin
                if (keep) begin
                    out_data_d  = CONF_RAW ? word_q : {word_q[31:22], tot, word_q[13:0]};
                    out_valid_d = 1'b1;
                    hit_inc     = 1'b1;
                    state_d     = SEND;
                end else begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            SEND: begin
                if (out_valid_q && OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pop strobe is registered: it is high exactly while the FSM sits in POP.
        in_read_d = (state_d == POP);

        if (CNT_CLR)                             hit_cnt_d = '0;
        else if (hit_inc && hit_cnt_q < CNT_MAX) hit_cnt_d = hit_cnt_q + 16'd1;
        else                                     hit_cnt_d = hit_cnt_q;

        if (CNT_CLR)                               drop_cnt_d = '0;
        else if (drop_inc && drop_cnt_q < CNT_MAX) drop_cnt_d = drop_cnt_q + 16'd1;
        else                                       drop_cnt_d = drop_cnt_q;
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            in_read_q   <= 1'b0;
            word_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            hit_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_read_q   <= in_read_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            hit_cnt_q   <= hit_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign IN_READ   = in_read_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign HIT_CNT   = hit_cnt_q;
    assign DROP_CNT  = drop_cnt_q;

endmodule
